// File: rtl/md_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package md_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;
endpackage

// File: rtl/md_iter_step.sv
// One iteration on {acc, opr}: shift-add for multiply, restoring step for divide.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opr_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  // Multiply: carry out of the add shifts into the top of the product.
  assign sum     = {1'b0, acc_i} + (opr_i[0] ? {1'b0, m_i} : '0);
  // Divide: shifted partial remainder needs one extra bit before the trial subtract.
  assign sh      = {acc_i, opr_i[WIDTH-1]};
  assign ge      = (sh >= {1'b0, m_i});
  assign rem_sub = sh[WIDTH-1:0] - m_i;

  always_comb begin
    acc_o = sum[WIDTH:1];
    opr_o = {sum[0], opr_i[WIDTH-1:1]};
    if (is_div_i) begin
      acc_o = ge ? rem_sub : sh[WIDTH-1:0];
      opr_o = {opr_i[WIDTH-2:0], ge};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned MULT/DIV with start/done handshake and HI/LO results.
module mult_div_unit
  import md_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_e        state_q;
  md_op_e           op_e;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, opr_q, m_q, hi_q, lo_q;
  logic [WIDTH-1:0] acc_d, opr_d;
  logic             is_div_q, sa_q, sb_q, busy_q, done_q, dz_q;
  logic             sgn, is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] q_s, r_s;

  assign op_e   = md_op_e'(op);
  assign sgn    = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn && b[WIDTH-1]) ? -b : b;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opr_i    (opr_q),
    .m_i      (m_q),
    .acc_o    (acc_d),
    .opr_o    (opr_d)
  );

  // Sign fix-up; the most-negative / -1 quotient wraps back to itself.
  assign prod   = {acc_q, opr_q};
  assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
  assign q_s    = (sa_q ^ sb_q) ? -opr_q : opr_q;
  assign r_s    = sa_q ? -acc_q : acc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            dz_q     <= 1'b0;
            is_div_q <= is_div;
            sa_q     <= sgn && a[WIDTH-1];
            sb_q     <= sgn && b[WIDTH-1];
            acc_q    <= '0;
            opr_q    <= abs_a;
            m_q      <= abs_b;
            cnt_q    <= '0;
            if (is_div && (b == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          opr_q <= opr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
          if (is_div_q) begin
            hi_q <= r_s;
            lo_q <= q_s;
          end else begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mhi = '0, mlo = '0;
  int          n_cmp = 0, n_err = 0;

  // Reference model built on native 64-bit arithmetic.
  task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    e.lat = 34;
    case (o)
      2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == 0) begin
          e.dz = 1'b1; e.lat = 1; e.hi = mhi; e.lo = mlo;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; e.hi = r[31:0]; e.lo = q[31:0];
        end else begin
          e.hi = x % y; e.lo = x / y;
        end
      end
    endcase
    mhi = e.hi;
    mlo = e.lo;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; the start is accepted at the following posedge.
  task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    push_exp(o, x, y);
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Returns the cycle index of done (-1 on timeout) and the busy cycles seen before it.
  task automatic wait_done(output int cyc, output int nbusy, output logic dz1);
    cyc = -1; nbusy = 0; dz1 = 1'bx;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) dz1 = div_zero;
      if (done) begin cyc = k; break; end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state busy=%b done=%b dz=%b hi=%h lo=%h required all zero", busy, done, div_zero, hi, lo);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int c, nb; logic d1; exp_t e;
    @(negedge clock);
    drive_start(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== e.lat) begin n_err++; $display("FAIL mult_latency got %0d required %0d", c, e.lat); end
    n_cmp++;
    if (nb !== 33 || busy !== 1'b0) begin n_err++; $display("FAIL mult_busy cycles=%0d busy_at_done=%b required 33/0", nb, busy); end
    n_cmp++;
    if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz)
      begin n_err++; $display("FAIL mult_result hi=%h lo=%h dz=%b required %h %h %b", hi, lo, div_zero, e.hi, e.lo, e.dz); end
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB)
      begin n_err++; $display("FAIL mult_const hi=%h lo=%h required ffffffff ffffffeb", hi, lo); end
  endtask

  task automatic test_multu;
    int c, nb; logic d1; exp_t e;
    @(negedge clock);
    drive_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== e.lat || hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
      begin n_err++; $display("FAIL multu_max cyc=%0d hi=%h lo=%h required 34 fffffffe 00000001", c, hi, lo); end
  endtask

  // DIV -7/2 then, straight from its DONE cycle, the overflow DIV.
  task automatic test_back_to_back;
    int c, nb; logic d1; exp_t e;
    @(negedge clock);
    drive_start(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== 34 || hi !== e.hi || lo !== e.lo || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF)
      begin n_err++; $display("FAIL div_neg cyc=%0d hi=%h lo=%h required 34 ffffffff fffffffd", c, hi, lo); end
    drive_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== 34) begin n_err++; $display("FAIL b2b_latency got %0d required 34", c); end
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'h80000000 || lo !== e.lo || hi !== e.hi)
      begin n_err++; $display("FAIL div_ovf hi=%h lo=%h required 00000000 80000000", hi, lo); end
  endtask

  task automatic test_div_zero;
    int c, nb; logic d1; exp_t e;
    logic [31:0] phi, plo;
    phi = hi; plo = lo;
    @(negedge clock);
    drive_start(2'b11, 32'd5, 32'd0);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== 1 || div_zero !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL divz_timing cyc=%0d dz=%b busy=%b required 1 1 0", c, div_zero, busy); end
    n_cmp++;
    if (hi !== e.hi || lo !== e.lo || hi !== phi || lo !== plo)
      begin n_err++; $display("FAIL divz_hold hi=%h lo=%h required %h %h", hi, lo, e.hi, e.lo); end
    drive_start(2'b01, 32'd3, 32'd4);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (d1 !== 1'b0) begin n_err++; $display("FAIL divz_clear dz_cycle1=%b required 0", d1); end
    n_cmp++;
    if (c !== 34 || hi !== 32'd0 || lo !== 32'd12 || div_zero !== 1'b0)
      begin n_err++; $display("FAIL multu_small cyc=%0d hi=%h lo=%h dz=%b required 34 0 c 0", c, hi, lo, div_zero); end
  endtask

  task automatic test_start_ignored;
    int c, nb; logic d1; exp_t e;
    @(negedge clock);
    drive_start(2'b00, 32'h00001234, 32'h00005678);
    repeat (5) @(negedge clock);
    op = 2'b11; a = 32'd99; b = 32'd0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c + 5 !== 34 || hi !== e.hi || lo !== e.lo || div_zero !== 1'b0)
      begin n_err++; $display("FAIL start_ignored cyc=%0d hi=%h lo=%h required 34 %h %h", c + 5, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_abort;
    int c, nb; logic d1; exp_t e;
    @(negedge clock);
    drive_start(2'b01, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0)
      begin n_err++; $display("FAIL reset_abort busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo); end
    sb_q.delete();
    mhi = '0; mlo = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    drive_start(2'b11, 32'd100, 32'd7);
    wait_done(c, nb, d1);
    e = sb_q.pop_front();
    n_cmp++;
    if (c !== 34 || hi !== 32'd2 || lo !== 32'd14 || hi !== e.hi || lo !== e.lo)
      begin n_err++; $display("FAIL divu_after_reset cyc=%0d hi=%h lo=%h required 34 2 e", c, hi, lo); end
  endtask

  task automatic test_random;
    int c, nb; logic d1; exp_t e;
    logic [1:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 2) x = 32'h80000000;
      @(negedge clock);
      drive_start(o, x, y);
      wait_done(c, nb, d1);
      e = sb_q.pop_front();
      n_cmp++;
      if (c !== e.lat || hi !== e.hi || lo !== e.lo || div_zero !== e.dz)
        begin n_err++; $display("FAIL random_%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h dz=%b required %0d %h %h %b",
          i, o, x, y, c, hi, lo, div_zero, e.lat, e.hi, e.lo, e.dz); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
